// File: rtl/key_decoder.sv
// Keypad front end: synchronizes the encoder's code/strobe, debounces each press,
// and builds a hex entry register with backspace, clear, enter and an error flag.
module key_decoder #(
    parameter int unsigned HOLD = 3
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [4:0]  code,
    input  logic        strobe,
    output logic        valid,
    output logic [19:0] onehot,
    output logic [31:0] digits,
    output logic [3:0]  count,
    output logic [31:0] value,
    output logic        err
);

    localparam logic [4:0] KeyBksp  = 5'd16;
    localparam logic [4:0] KeyClear = 5'd17;
    localparam logic [4:0] KeyEnter = 5'd18;
    localparam logic [4:0] KeyLast  = 5'd19;
    localparam logic [3:0] HoldCnt  = 4'(HOLD);

    typedef enum logic [1:0] {
        StIdle,
        StQual,
        StAccept,
        StWaitRel
    } state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_qcnt, w_qcnt_nxt;
    logic [4:0]  r_kcode, w_kcode_nxt;

    logic [4:0]  r_code_meta, r_code_sync;
    logic        r_strobe_meta, r_strobe_sync;

    logic [31:0] r_digits;
    logic [3:0]  r_count;
    logic [31:0] r_value;
    logic        r_err;

    // Two-flop synchronizers; the FSM sees only the *_sync copies.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_code_meta   <= 5'd0;
            r_code_sync   <= 5'd0;
            r_strobe_meta <= 1'b0;
            r_strobe_sync <= 1'b0;
        end else begin
            r_code_meta   <= code;
            r_code_sync   <= r_code_meta;
            r_strobe_meta <= strobe;
            r_strobe_sync <= r_strobe_meta;
        end
    end

    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_qcnt  <= 4'd0;
            r_kcode <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_qcnt  <= w_qcnt_nxt;
            r_kcode <= w_kcode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_qcnt_nxt  = r_qcnt;
        w_kcode_nxt = r_kcode;
        unique case (r_state)
            StIdle: begin
                if (r_strobe_sync) begin
                    w_state_nxt = StQual;
                    w_kcode_nxt = r_code_sync;
                    w_qcnt_nxt  = 4'd1;
                end
            end
            StQual: begin
                if (!r_strobe_sync) begin
                    w_state_nxt = StIdle;
                end else if (r_code_sync != r_kcode) begin
                    // Code moved under a held strobe: restart qualification on the new key.
                    w_kcode_nxt = r_code_sync;
                    w_qcnt_nxt  = 4'd1;
                end else if (r_qcnt == HoldCnt) begin
                    w_state_nxt = StAccept;
                end else begin
                    w_qcnt_nxt = r_qcnt + 4'd1;
                end
            end
            StAccept: begin
                w_state_nxt = StWaitRel;
            end
            StWaitRel: begin
                if (!r_strobe_sync) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Key action takes effect on the edge that leaves StAccept.
    always_ff @(posedge hz100 or negedge reset) begin
        if (!reset) begin
            r_digits <= 32'd0;
            r_count  <= 4'd0;
            r_value  <= 32'd0;
            r_err    <= 1'b0;
        end else if (r_state == StAccept) begin
            if (r_kcode < KeyBksp) begin
                r_digits <= {r_digits[27:0], r_kcode[3:0]};
                if (r_count < 4'd8) begin
                    r_count <= r_count + 4'd1;
                end
            end else if (r_kcode == KeyBksp) begin
                r_digits <= {4'h0, r_digits[31:4]};
                if (r_count != 4'd0) begin
                    r_count <= r_count - 4'd1;
                end
            end else if (r_kcode == KeyClear) begin
                r_digits <= 32'd0;
                r_count  <= 4'd0;
                r_err    <= 1'b0;
            end else if (r_kcode == KeyEnter) begin
                r_value <= r_digits;
            end else if (r_kcode > KeyLast) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        valid  = (r_state == StAccept);
        onehot = 20'd0;
        if (valid && (r_kcode <= KeyLast)) begin
            onehot = 20'd1 << r_kcode;
        end
    end

    assign digits = r_digits;
    assign count  = r_count;
    assign value  = r_value;
    assign err    = r_err;

endmodule
